// File: rtl/bike_light_ctrl_pkg.sv
// Shared mode encodings, width helpers and mode-step functions for the bike light controller.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package bike_light_ctrl_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
    localparam logic [MODE_W-1:0] MODE_ALT   = 2'd3;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Width of a speed exponent that must hold 0..max_spd.
    function automatic int spd_width(input int max_spd);
        return (max_spd > 0) ? $clog2(max_spd + 1) : 1;
    endfunction

    // Modes advance OFF -> ON -> BLINK -> ALT and wrap back to OFF.
    function automatic logic [MODE_W-1:0] mode_step(input logic [MODE_W-1:0] m);
        return m + 1'b1;
    endfunction

    function automatic logic is_blinking(input logic [MODE_W-1:0] m);
        return (m == MODE_BLINK) || (m == MODE_ALT);
    endfunction

endpackage

// File: rtl/bike_light_ctrl_if.sv
// Button, select and light/status bundle between the rider controls and the light controller.
// Latency: none (wires only).
// Backpressure: none; buttons are levels and outputs are continuously valid.
interface bike_light_ctrl_if #(
    parameter int N_CH    = 2,
    parameter int MAX_SPD = 4
);
    import bike_light_ctrl_pkg::*;

    localparam int SEL_W = sel_width(N_CH);
    localparam int SPD_W = spd_width(MAX_SPD);

    logic              next;
    logic              faster;
    logic              slower;
    logic [SEL_W-1:0]  sel;
    logic [N_CH-1:0]   light;
    logic [MODE_W-1:0] mode_o;
    logic [SPD_W-1:0]  spd_o;

    modport master (
        output next, faster, slower, sel,
        input  light, mode_o, spd_o
    );

    modport slave (
        input  next, faster, slower, sel,
        output light, mode_o, spd_o
    );

endinterface

// File: rtl/bike_blink_channel.sv
// One light channel: mode, speed exponent, beat counter and blink phase, plus the registered light bit.
// Latency: mode/spd update on the strobe clock; light follows one clock later.
// Backpressure: none; a strobe is always accepted (adv > spd change > force_off > beat).
module bike_blink_channel
    import bike_light_ctrl_pkg::*;
#(
    parameter int MAX_SPD = 4,
    parameter int RST_SPD = 2,
    parameter int SPD_W   = spd_width(MAX_SPD)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              beat,
    input  logic              adv,
    input  logic              inc,
    input  logic              dec,
    input  logic              force_off,
    input  logic              chan_idx0,
    output logic              light,
    output logic [MODE_W-1:0] mode,
    output logic [SPD_W-1:0]  spd
);

    logic [MAX_SPD-1:0] bc;
    logic [MAX_SPD-1:0] thr;
    logic               phase;
    logic               spd_up;
    logic               spd_dn;

    // Saturated requests are not speed changes, so they leave the beat counter alone.
    assign spd_up = inc && (spd != SPD_W'(MAX_SPD));
    assign spd_dn = dec && (spd != '0);

    // Terminal beat count for the current speed: 2^spd - 1 as a run of low ones.
    always_comb begin
        thr = '0;
        for (int k = 0; k < MAX_SPD; k++) begin
            thr[k] = (SPD_W'(k) < spd);
        end
    end

    // Channel state; a mode or speed update on a beat clock swallows that beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode  <= MODE_OFF;
            spd   <= SPD_W'(RST_SPD);
            bc    <= '0;
            phase <= 1'b0;
            light <= 1'b0;
        end else begin
            if (adv) begin
                mode  <= mode_step(mode);
                bc    <= '0;
                // Entering a blinking mode starts with the light on.
                phase <= is_blinking(mode_step(mode));
            end else if (spd_up || spd_dn) begin
                spd <= spd_up ? spd + 1'b1 : spd - 1'b1;
                bc  <= '0;
            end else if (force_off) begin
                mode  <= MODE_OFF;
                bc    <= '0;
                phase <= 1'b0;
            end else if (!is_blinking(mode)) begin
                bc    <= '0;
                phase <= 1'b0;
            end else if (beat) begin
                if (bc == thr) begin
                    bc    <= '0;
                    phase <= ~phase;
                end else begin
                    bc <= bc + 1'b1;
                end
            end

            case (mode)
                MODE_ON:    light <= 1'b1;
                MODE_BLINK: light <= phase;
                MODE_ALT:   light <= phase ^ chan_idx0;
                default:    light <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/bike_light_ctrl.sv
// Multi-channel bike light controller: button edge detect, beat divider, idle auto-off, channel select.
// Latency: selected channel's mode/spd change on the clock that first samples a press; light one clock later.
// Backpressure: none; every edge on a valid select is acted on, edges on an invalid select are dropped.
module bike_light_ctrl
    import bike_light_ctrl_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int TICK_DIV   = 32,
    parameter int MAX_SPD    = 4,
    parameter int RST_SPD    = 2,
    parameter int IDLE_BEATS = 0
) (
    input  logic           clk,
    input  logic           reset_n,
    bike_light_ctrl_if.slave bus
);

    localparam int SEL_W = sel_width(N_CH);
    localparam int SPD_W = spd_width(MAX_SPD);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic              next_q;
    logic              faster_q;
    logic              slower_q;
    logic              next_edge;
    logic              faster_edge;
    logic              slower_edge;
    logic              any_edge;
    logic [DIV_W-1:0]  div_cnt;
    logic              beat;
    logic              force_off;
    logic [N_CH-1:0]   light_q;
    logic [MODE_W-1:0] ch_mode [N_CH];
    logic [SPD_W-1:0]  ch_spd  [N_CH];
    logic [MODE_W-1:0] mode_mux;
    logic [SPD_W-1:0]  spd_mux;

    assign next_edge   = bus.next   & ~next_q;
    assign faster_edge = bus.faster & ~faster_q;
    assign slower_edge = bus.slower & ~slower_q;
    assign any_edge    = next_edge | faster_edge | slower_edge;
    assign beat        = (div_cnt == DIV_W'(TICK_DIV - 1));

    // Previous button levels for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_q   <= 1'b0;
            faster_q <= 1'b0;
            slower_q <= 1'b0;
        end else begin
            next_q   <= bus.next;
            faster_q <= bus.faster;
            slower_q <= bus.slower;
        end
    end

    // Free-running beat divider shared by all channels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (beat) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    generate
        if (IDLE_BEATS > 0) begin : g_idle
            localparam int IDLE_W = $clog2(IDLE_BEATS + 1);
            logic [IDLE_W-1:0] idle_cnt;

            // Beats since the last button edge, holding once the limit is reached.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    idle_cnt <= '0;
                end else if (any_edge) begin
                    idle_cnt <= '0;
                end else if (beat && (idle_cnt != IDLE_W'(IDLE_BEATS))) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end

            // Switch off on the beat that reaches the limit and keep forcing while held there.
            assign force_off = !any_edge &&
                               ((idle_cnt == IDLE_W'(IDLE_BEATS)) ||
                                (beat && (idle_cnt == IDLE_W'(IDLE_BEATS - 1))));
        end else begin : g_no_idle
            assign force_off = 1'b0;
        end
    endgenerate

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            logic hit;
            assign hit = (bus.sel == SEL_W'(g));

            // next outranks speed; faster and slower together cancel.
            bike_blink_channel #(
                .MAX_SPD (MAX_SPD),
                .RST_SPD (RST_SPD),
                .SPD_W   (SPD_W)
            ) u_ch (
                .clk       (clk),
                .reset_n   (reset_n),
                .beat      (beat),
                .adv       (hit & next_edge),
                .inc       (hit & slower_edge & ~faster_edge & ~next_edge),
                .dec       (hit & faster_edge & ~slower_edge & ~next_edge),
                .force_off (force_off),
                .chan_idx0 ((g % 2) == 1),
                .light     (light_q[g]),
                .mode      (ch_mode[g]),
                .spd       (ch_spd[g])
            );
        end
    endgenerate

    // Status of the selected channel; zeros when the select points past the last channel.
    always_comb begin
        mode_mux = MODE_OFF;
        spd_mux  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                mode_mux = ch_mode[i];
                spd_mux  = ch_spd[i];
            end
        end
    end

    assign bus.light  = light_q;
    assign bus.mode_o = mode_mux;
    assign bus.spd_o  = spd_mux;

endmodule

// File: tb/tb_bike_light_ctrl.sv
module tb_bike_light_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc;

    always #5 clk = ~clk;

    // Posedges since reset release; the divider beats on posedge numbers that are multiples of 4.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    bike_light_ctrl_if #(.N_CH(2), .MAX_SPD(2)) bus0 ();
    bike_light_ctrl_if #(.N_CH(3), .MAX_SPD(2)) bus1 ();

    bike_light_ctrl #(
        .N_CH(2), .TICK_DIV(4), .MAX_SPD(2), .RST_SPD(1), .IDLE_BEATS(0)
    ) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    bike_light_ctrl #(
        .N_CH(3), .TICK_DIV(4), .MAX_SPD(2), .RST_SPD(1), .IDLE_BEATS(5)
    ) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One-clock button press on bench 0 starting at a negedge; returns two negedges later.
    task automatic press0(input logic nx, input logic fs, input logic sl);
        bus0.next = nx; bus0.faster = fs; bus0.slower = sl;
        @(negedge clk);
        bus0.next = 1'b0; bus0.faster = 1'b0; bus0.slower = 1'b0;
        @(negedge clk);
    endtask

    task automatic press1(input logic nx, input logic fs, input logic sl);
        bus1.next = nx; bus1.faster = fs; bus1.slower = sl;
        @(negedge clk);
        bus1.next = 1'b0; bus1.faster = 1'b0; bus1.slower = 1'b0;
        @(negedge clk);
    endtask

    // Sync to a rising light[0] then a falling one, then measure low/high/low run lengths.
    task automatic blink_runs(input int exp_len, input string tag);
        int n;
        n = 0;
        while (bus0.light[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (bus0.light[0] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        for (int r = 0; r < 3; r++) begin
            logic lvl;
            lvl = (r % 2 == 1);
            n = 0;
            while (bus0.light[0] === lvl && n < 100) begin n++; @(negedge clk); end
            chk(tag, n, exp_len);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        int saw01;
        int saw10;

        reset_n = 1'b0;
        bus0.next = 0; bus0.faster = 0; bus0.slower = 0; bus0.sel = '0;
        bus1.next = 0; bus1.faster = 0; bus1.slower = 0; bus1.sel = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_light", bus0.light, 0);
        chk("rst_mode",  bus0.mode_o, 0);
        chk("rst_spd",   bus0.spd_o, 1);
        reset_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus0.light != 2'b00) bad++;
        end
        chk("idle_dark", bad, 0);

        // Mode cycle on channel 0
        bus0.next = 1'b1;
        @(negedge clk);
        chk("mode_on", bus0.mode_o, 1);
        chk("light_lag", bus0.light[0], 0);
        bus0.next = 1'b0;
        @(negedge clk);
        chk("light_on", bus0.light[0], 1);
        for (int m = 2; m <= 4; m++) begin
            press0(1, 0, 0);
            chk("mode_cycle", bus0.mode_o, m % 4);
            chk("ch1_dark", bus0.light[1], 0);
        end

        // Blink timing at spd 1 then saturating slower to spd 2
        press0(1, 0, 0);
        press0(1, 0, 0);
        chk("blink_mode", bus0.mode_o, 2);
        blink_runs(8, "blink_half_s1");
        press0(0, 0, 1);
        chk("slower_1", bus0.spd_o, 2);
        press0(0, 0, 1);
        chk("slower_sat", bus0.spd_o, 2);
        blink_runs(16, "blink_half_s2");

        // Priority and saturation
        press0(1, 1, 0);
        chk("prio_mode", bus0.mode_o, 3);
        chk("prio_spd",  bus0.spd_o, 2);
        press0(0, 1, 0);
        chk("faster_1", bus0.spd_o, 1);
        press0(0, 1, 1);
        chk("both_spd",  bus0.spd_o, 1);
        chk("both_mode", bus0.mode_o, 3);
        press0(0, 1, 0);
        chk("faster_0", bus0.spd_o, 0);
        press0(0, 1, 0);
        chk("faster_sat", bus0.spd_o, 0);

        // ALT antiphase: fresh reset, both channels to BLINK, then both into ALT
        // within one beat interval so their beat counters and phases stay aligned.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus0.sel = 1'b0;
        press0(1, 0, 0);
        press0(1, 0, 0);
        bus0.sel = 1'b1;
        press0(1, 0, 0);
        press0(1, 0, 0);
        bus0.sel = 1'b0;
        while ((cyc + 1) % 4 != 1) @(negedge clk);
        bus0.next = 1'b1;
        @(negedge clk);
        bus0.next = 1'b0;
        bus0.sel  = 1'b1;
        @(negedge clk);
        bus0.next = 1'b1;
        @(negedge clk);
        bus0.next = 1'b0;
        chk("alt_mode_ch1", bus0.mode_o, 3);
        repeat (2) @(negedge clk);
        bad = 0; saw01 = 0; saw10 = 0;
        repeat (64) begin
            @(negedge clk);
            if (bus0.light == 2'b00 || bus0.light == 2'b11) bad++;
            if (bus0.light == 2'b01) saw01 = 1;
            if (bus0.light == 2'b10) saw10 = 1;
        end
        chk("alt_bad",   bad, 0);
        chk("alt_saw01", saw01, 1);
        chk("alt_saw10", saw10, 1);

        // Asynchronous reset while blinking
        chk("pre_rst_lit", int'(bus0.light != 2'b00), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_light", bus0.light, 0);
        chk("async_rst_mode",  bus0.mode_o, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Invalid select on the 3-channel idle bench
        bus1.sel = 2'd0;
        press1(1, 0, 0);
        chk("b1_on", bus1.mode_o, 1);
        bus1.sel = 2'd3;
        @(negedge clk);
        chk("inv_mode", bus1.mode_o, 0);
        chk("inv_spd",  bus1.spd_o, 0);
        press1(1, 0, 1);
        press1(0, 1, 0);
        bus1.sel = 2'd0;
        @(negedge clk);
        chk("inv_keep_mode", bus1.mode_o, 1);
        chk("inv_keep_spd",  bus1.spd_o, 1);

        // Idle auto-off after 5 beats (20 clk) with no edge
        repeat (4) press1(1, 0, 0);
        chk("idle_start_mode", bus1.mode_o, 1);
        repeat (10) @(negedge clk);
        chk("idle_still_on", bus1.light[0], 1);
        repeat (12) @(negedge clk);
        chk("idle_off_light", bus1.light, 0);
        chk("idle_off_mode",  bus1.mode_o, 0);
        chk("idle_keep_spd",  bus1.spd_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
